// File: rtl/csr_file_if.sv
// CSR access bus between the execute/writeback stage (master) and the CSR file (slave).
// No handshake: an access presented with csr_valid is consumed on the same clock edge;
// csr_rdata and csr_illegal are combinational responses to the current request.
interface csr_file_if #(
    parameter int XLEN = 32
);
    logic            csr_valid;
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_valid, csr_addr, csr_op, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_valid, csr_addr, csr_op, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: addressed read/write/set/clear, trap entry and mret sequencing,
// timer-interrupt gating and a free-running 64-bit cycle counter.
module csr_file #(
    parameter int              XLEN          = 32,
    parameter logic [31:0]     MSTATUS_RESET = 32'h1800,
    parameter logic [XLEN-1:0] MTVEC_RESET   = '0,
    parameter logic [XLEN-1:0] HART_ID       = '0,
    parameter bit              CYCLE_EN      = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    csr_file_if.slave       bus,
    input  logic [XLEN-1:0] pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic            mret,
    input  logic            irq_timer,
    output logic            irq_pending,
    output logic [XLEN-1:0] mtvec_out,
    output logic [XLEN-1:0] mepc_out,
    output logic [XLEN-1:0] mstatus_out,
    output logic [XLEN-1:0] mcause_out
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    logic            mie_q, mpie_q, mtie_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0]     cycle_q, cycle_inc, cycle_next;

    logic [XLEN-1:0] mstatus_val, rdata, wval;
    logic            mapped, read_only, illegal, wr;

    // MPP is hard-wired to machine mode; only MIE and MPIE have storage.
    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mpie_q;
        mstatus_val[3]     = mie_q;
    end

    always_comb begin
        rdata     = '0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (bus.csr_addr)
            A_MSTATUS:  rdata = mstatus_val;
            A_MIE:      rdata[7] = mtie_q;
            A_MTVEC:    rdata = mtvec_q;
            A_MSCRATCH: rdata = mscratch_q;
            A_MEPC:     rdata = mepc_q;
            A_MCAUSE:   rdata = mcause_q;
            A_MIP: begin
                rdata[7]  = irq_timer;
                read_only = 1'b1;
            end
            A_MCYCLE:   rdata = cycle_q[XLEN-1:0];
            A_MCYCLEH: begin
                if (XLEN == 32) rdata = XLEN'(cycle_q[63:32]);
                else            mapped = 1'b0;
            end
            A_MHARTID: begin
                rdata     = HART_ID;
                read_only = 1'b1;
            end
            default:    mapped = 1'b0;
        endcase
    end

    always_comb begin
        illegal = bus.csr_valid && (!mapped || (bus.csr_op != 2'b00 && read_only));
        wr      = bus.csr_valid && (bus.csr_op != 2'b00) && !illegal;
        case (bus.csr_op)
            2'b01:   wval = bus.csr_wdata;
            2'b10:   wval = rdata | bus.csr_wdata;
            2'b11:   wval = rdata & ~bus.csr_wdata;
            default: wval = rdata;
        endcase
    end

    // A written half is replaced outright; the other half takes the pre-write count + 1.
    always_comb begin
        cycle_inc  = cycle_q + 64'd1;
        cycle_next = cycle_inc;
        if (!CYCLE_EN) begin
            cycle_next = '0;
        end else if (wr && bus.csr_addr == A_MCYCLE) begin
            if (XLEN == 32) cycle_next[31:0] = wval[31:0];
            else            cycle_next = 64'(wval);
        end else if (wr && bus.csr_addr == A_MCYCLEH && XLEN == 32) begin
            cycle_next[63:32] = wval[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= MSTATUS_RESET[3];
            mpie_q     <= MSTATUS_RESET[7];
            mtie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            cycle_q    <= '0;
        end else begin
            if (trap_valid) begin
                mpie_q <= mie_q;
                mie_q  <= 1'b0;
            end else if (mret) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (wr && bus.csr_addr == A_MSTATUS) begin
                mie_q  <= wval[3];
                mpie_q <= wval[7];
            end

            if (wr && bus.csr_addr == A_MIE)      mtie_q     <= wval[7];
            if (wr && bus.csr_addr == A_MTVEC)    mtvec_q    <= {wval[XLEN-1:2], 2'b00};
            if (wr && bus.csr_addr == A_MSCRATCH) mscratch_q <= wval;

            if (trap_valid)                       mepc_q <= {pc[XLEN-1:2], 2'b00};
            else if (wr && bus.csr_addr == A_MEPC) mepc_q <= {wval[XLEN-1:2], 2'b00};

            if (trap_valid)                         mcause_q <= trap_cause;
            else if (wr && bus.csr_addr == A_MCAUSE) mcause_q <= wval;

            cycle_q <= cycle_next;
        end
    end

    assign bus.csr_rdata   = rdata;
    assign bus.csr_illegal = illegal;
    assign irq_pending     = mie_q & mtie_q & irq_timer;
    assign mtvec_out       = mtvec_q;
    assign mepc_out        = mepc_q;
    assign mstatus_out     = mstatus_val;
    assign mcause_out      = mcause_q;
endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file (XLEN = 32): directed vector table, hand-written
// trap/interrupt/counter sequences and random traffic against a register-level model.
module tb_csr_file;
  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  logic [31:0] pc, trap_cause;
  logic trap_valid, mret, irq_timer;
  logic irq_pending;
  logic [31:0] mtvec_out, mepc_out, mstatus_out, mcause_out;

  csr_file_if #(.XLEN(XLEN)) bus ();

  csr_file #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .pc(pc), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .mret(mret), .irq_timer(irq_timer), .irq_pending(irq_pending),
    .mtvec_out(mtvec_out), .mepc_out(mepc_out),
    .mstatus_out(mstatus_out), .mcause_out(mcause_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_mie, m_mpie, m_mtie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cnt;

  logic [31:0] s_rdata;
  logic        s_ill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mtie = 0;
    m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cnt = 0;
  endtask

  function automatic logic [31:0] m_mstatus();
    return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
  endfunction

  function automatic bit m_mapped(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'h344, 12'hB00, 12'hB80, 12'hF14};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a, input bit irq);
    case (a)
      12'h300: return m_mstatus();
      12'h304: return m_mtie ? 32'h80 : 32'h0;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return irq ? 32'h80 : 32'h0;
      12'hB00: return m_cnt[31:0];
      12'hB80: return m_cnt[63:32];
      12'hF14: return 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // Drive one cycle, compare combinational outputs against the model, then advance both.
  task automatic step(input bit v, input logic [11:0] a, input logic [1:0] op,
                      input logic [31:0] wd, input bit tr, input logic [31:0] tpc,
                      input logic [31:0] tcause, input bit mr, input bit irq);
    logic [31:0] old, nv;
    bit ill, we, o_mie, o_mpie;
    bus.csr_valid = v; bus.csr_addr = a; bus.csr_op = op; bus.csr_wdata = wd;
    trap_valid = tr; pc = tpc; trap_cause = tcause; mret = mr; irq_timer = irq;
    #1;
    old = m_read(a, irq);
    ill = v && (!m_mapped(a) || (op != 2'b00 && (a == 12'h344 || a == 12'hF14)));
    s_rdata = bus.csr_rdata;
    s_ill   = bus.csr_illegal;
    check("rdata", s_rdata, old);
    check("illegal", 32'(s_ill), 32'(ill));
    check("irq_pending", 32'(irq_pending), 32'(m_mie & m_mtie & irq));
    check("mstatus_out", mstatus_out, m_mstatus());
    check("mepc_out", mepc_out, m_mepc);
    check("mcause_out", mcause_out, m_mcause);
    check("mtvec_out", mtvec_out, m_mtvec);
    nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
    we = v && op != 2'b00 && !ill;
    o_mie = m_mie; o_mpie = m_mpie;
    begin
      logic [63:0] cnt_n;
      cnt_n = m_cnt + 64'd1;
      if (we) begin
        case (a)
          12'h300: if (!tr && !mr) begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_mtie = nv[7];
          12'h305: m_mtvec = nv & ~32'h3;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv;
          12'hB00: cnt_n[31:0] = nv;
          12'hB80: cnt_n[63:32] = nv;
          default: ;
        endcase
      end
      if (tr) begin
        m_mepc = tpc & ~32'h3; m_mcause = tcause; m_mpie = o_mie; m_mie = 0;
      end else if (mr) begin
        m_mie = o_mpie; m_mpie = 1;
      end
      m_cnt = cnt_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit irq);
    step(0, 12'h000, 2'b00, 32'h0, 0, 32'h0, 32'h0, 0, irq);
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    step(1, a, op, wd, 0, 32'h0, 32'h0, 0, 0);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{12'h340, 2'b01, 32'hA5A5A5A5, 32'h00000000, 1'b0};
    vecs[1]  = '{12'h340, 2'b10, 32'h0000000F, 32'hA5A5A5A5, 1'b0};
    vecs[2]  = '{12'h340, 2'b11, 32'hA0000000, 32'hA5A5A5AF, 1'b0};
    vecs[3]  = '{12'h340, 2'b00, 32'h0,        32'h05A5A5AF, 1'b0};
    vecs[4]  = '{12'h341, 2'b01, 32'h80000003, 32'h00000000, 1'b0};
    vecs[5]  = '{12'h341, 2'b00, 32'h0,        32'h80000000, 1'b0};
    vecs[6]  = '{12'hF14, 2'b01, 32'h00000001, 32'h00000000, 1'b1};
    vecs[7]  = '{12'h7C0, 2'b01, 32'h12345678, 32'h00000000, 1'b1};
    vecs[8]  = '{12'hF14, 2'b00, 32'h0,        32'h00000000, 1'b0};
    vecs[9]  = '{12'h7C0, 2'b00, 32'h0,        32'h00000000, 1'b1};
    vecs[10] = '{12'h344, 2'b10, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[11] = '{12'h305, 2'b00, 32'h0,        32'h00000000, 1'b0};
    vecs[12] = '{12'h305, 2'b01, 32'h00000103, 32'h00000000, 1'b0};
    vecs[13] = '{12'h305, 2'b00, 32'h0,        32'h00000100, 1'b0};
    vecs[14] = '{12'h304, 2'b01, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[15] = '{12'h304, 2'b00, 32'h0,        32'h00000080, 1'b0};
    vecs[16] = '{12'h300, 2'b01, 32'hFFFFFFFF, 32'h00001800, 1'b0};
    vecs[17] = '{12'h300, 2'b00, 32'h0,        32'h00001888, 1'b0};
    vecs[18] = '{12'h300, 2'b11, 32'hFFFFFFFF, 32'h00001888, 1'b0};
    vecs[19] = '{12'h300, 2'b00, 32'h0,        32'h00001800, 1'b0};

    // reset
    rst_n = 1'b0;
    bus.csr_valid = 0; bus.csr_addr = 0; bus.csr_op = 0; bus.csr_wdata = 0;
    pc = 0; trap_valid = 0; trap_cause = 0; mret = 0; irq_timer = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset mstatus_out", mstatus_out, 32'h1800);
    check("reset mepc_out", mepc_out, 32'h0);
    check("reset irq_pending", 32'(irq_pending), 32'h0);
    rst_n = 1'b1;
    repeat (5) idle(0);
    csr(12'hB00, 2'b00, 32'h0);
    check("mcycle after 5", s_rdata, 32'd5);
    csr(12'hF14, 2'b00, 32'h0);
    check("mhartid", s_rdata, 32'h0);
    csr(12'h300, 2'b00, 32'h0);
    check("mstatus reset read", s_rdata, 32'h1800);
    foreach (vecs[i]) begin
      csr(vecs[i].addr, vecs[i].op, vecs[i].wdata);
      check($sformatf("vec%0d rdata", i), s_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d illegal", i), 32'(s_ill), 32'(vecs[i].exp_ill));
    end
    csr(12'h340, 2'b00, 32'h0);
    check("mscratch untouched by illegal", s_rdata, 32'h05A5A5AF);

    // trap and return
    csr(12'h304, 2'b01, 32'h0);
    csr(12'h300, 2'b10, 32'h8);
    step(0, 12'h0, 2'b00, 32'h0, 1, 32'h80000010, 32'd11, 0, 0);
    check("trap mepc", mepc_out, 32'h80000010);
    check("trap mcause", mcause_out, 32'd11);
    check("trap mstatus", mstatus_out, 32'h1880);
    step(0, 12'h0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 1, 0);
    check("mret mstatus", mstatus_out, 32'h1888);

    // interrupt gating
    step(1, 12'h304, 2'b00, 32'h0, 0, 0, 0, 0, 1);
    check("irq gated by mtie", 32'(irq_pending), 32'h0);
    step(1, 12'h304, 2'b10, 32'h80, 0, 0, 0, 0, 1);
    step(1, 12'h344, 2'b00, 32'h0, 0, 0, 0, 0, 1);
    check("irq pending", 32'(irq_pending), 32'h1);
    check("mip read", s_rdata, 32'h80);
    step(0, 12'h0, 2'b00, 32'h0, 1, 32'h80000040, 32'h80000007, 0, 1);
    check("irq drops after trap", 32'(irq_pending), 32'h0);

    // collisions
    step(1, 12'h341, 2'b01, 32'h1234, 1, 32'h80000020, 32'd11, 0, 0);
    check("trap beats mepc write", mepc_out, 32'h80000020);
    step(1, 12'h340, 2'b01, 32'h55, 1, 32'h80000024, 32'd2, 0, 0);
    csr(12'h340, 2'b00, 32'h0);
    check("trap plus mscratch write", s_rdata, 32'h55);
    step(1, 12'h300, 2'b10, 32'h8, 0, 0, 0, 1, 0);
    check("mret beats mstatus write", mstatus_out, 32'h1880);

    // counter wrap and write-while-counting
    csr(12'hB80, 2'b01, 32'hFFFFFFFF);
    csr(12'hB00, 2'b01, 32'hFFFFFFFE);
    idle(0);
    idle(0);
    csr(12'hB00, 2'b00, 32'h0);
    check("wrap low", s_rdata, 32'h0);
    csr(12'hB80, 2'b00, 32'h0);
    check("wrap high", s_rdata, 32'h0);
    csr(12'hB00, 2'b01, 32'h00001000);
    csr(12'hB00, 2'b00, 32'h0);
    check("mcycle written", s_rdata, 32'h00001000);
    csr(12'hB00, 2'b00, 32'h0);
    check("mcycle written plus 1", s_rdata, 32'h00001001);

    // random traffic
    begin
      logic [11:0] addrs[12];
      addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                12'h344, 12'hB00, 12'hB80, 12'hF14, 12'h7C0, 12'h000};
      for (int n = 0; n < 400; n++) begin
        step($urandom_range(0, 3) != 0, addrs[$urandom_range(0, 11)],
             2'($urandom_range(0, 3)), $urandom(), $urandom_range(0, 7) == 0,
             $urandom(), $urandom(), $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
      end
    end

    // reset in the middle of a trap + write
    csr(12'h340, 2'b01, 32'hDEADBEEF);
    bus.csr_valid = 1; bus.csr_addr = 12'h341; bus.csr_op = 2'b01; bus.csr_wdata = 32'h44;
    trap_valid = 1; pc = 32'h80000100; trap_cause = 32'd3;
    #1 rst_n = 1'b0;
    #1;
    check("async reset mepc", mepc_out, 32'h0);
    check("async reset mstatus", mstatus_out, 32'h1800);
    @(posedge clk);
    #1;
    check("reset holds over trap", mcause_out, 32'h0);
    model_reset();
    trap_valid = 0;
    rst_n = 1'b1;
    csr(12'h340, 2'b00, 32'h0);
    check("mscratch after reset", s_rdata, 32'h0);
    csr(12'hB00, 2'b00, 32'h0);
    check("mcycle first edge", s_rdata, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
